// File: rtl/test_seq_pkg.sv
// Shared definitions for the production-test sequencer: FSM encodings,
// test index constants and a small one-hot helper.
package test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    PULSE      = 3'd2,
    WAIT_START = 3'd3,
    WAIT_END   = 3'd4,
    NEXT       = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [1:0] T_MEMF  = 2'd0;
  localparam logic [1:0] T_MEMS  = 2'd1;
  localparam logic [1:0] T_SD    = 2'd2;
  localparam logic [1:0] T_FLASH = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Production-test scheduler: pulses each enabled tester's init line in turn,
// tracks its progress/result handshake and records pass/fail/timeout bits.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int INIT_CYCLES    = 4,
  parameter int START_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 7000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] test_enable,
  input  logic [3:0] manual_req,
  input  logic       mem_progress,
  input  logic       mem_result,
  input  logic       sd_progress,
  input  logic       sd_result,
  input  logic       flash_progress,
  input  logic       flash_result,
  output logic [3:0] init,
  output logic       busy,
  output logic       done,
  output logic       all_pass,
  output logic [3:0] fail_mask,
  output logic [3:0] tmo_mask,
  output logic [1:0] cur_test,
  output state_t     fsm_state
);

  localparam int MAX_A = (INIT_CYCLES > START_CYCLES) ? INIT_CYCLES : START_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LD_INIT  = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_START = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] LD_TMO   = CW'(TIMEOUT_CYCLES - 1);

  logic mem_prog_s, mem_res_s, sd_prog_s, sd_res_s, flash_prog_s, flash_res_s;

  sync2 u_sync_mem_prog   (.clk(clk), .rst_n(rst_n), .d(mem_progress),   .q(mem_prog_s));
  sync2 u_sync_mem_res    (.clk(clk), .rst_n(rst_n), .d(mem_result),     .q(mem_res_s));
  sync2 u_sync_sd_prog    (.clk(clk), .rst_n(rst_n), .d(sd_progress),    .q(sd_prog_s));
  sync2 u_sync_sd_res     (.clk(clk), .rst_n(rst_n), .d(sd_result),      .q(sd_res_s));
  sync2 u_sync_flash_prog (.clk(clk), .rst_n(rst_n), .d(flash_progress), .q(flash_prog_s));
  sync2 u_sync_flash_res  (.clk(clk), .rst_n(rst_n), .d(flash_result),   .q(flash_res_s));

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    cur, cur_nx;
  logic [3:0]    fail_q, fail_nx, tmo_q, tmo_nx, init_q, init_nx;
  logic          aborted, aborted_nx;
  logic          prog_sel, res_sel, in_run;

  // Tester handshake: progress rises once the test starts; result is only
  // meaningful in the cycle the synced progress is seen low again.
  always_comb begin
    prog_sel = 1'b0;
    res_sel  = 1'b0;
    case (cur)
      T_MEMF, T_MEMS: begin prog_sel = mem_prog_s;   res_sel = mem_res_s;   end
      T_SD:           begin prog_sel = sd_prog_s;    res_sel = sd_res_s;    end
      default:        begin prog_sel = flash_prog_s; res_sel = flash_res_s; end
    endcase
  end

  assign in_run = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    fail_nx    = fail_q;
    tmo_nx     = tmo_q;
    aborted_nx = aborted;
    init_nx    = 4'b0000;
    case (state)
      IDLE, DONE: begin
        init_nx = manual_req;
        if (start && !abort) begin
          state_nx   = SELECT;
          cur_nx     = 2'd0;
          fail_nx    = 4'b0000;
          tmo_nx     = 4'b0000;
          aborted_nx = 1'b0;
          init_nx    = 4'b0000;
        end
      end
      SELECT: state_nx = test_enable[cur] ? PULSE : NEXT;
      PULSE: if (cnt == '0) state_nx = WAIT_START;
      WAIT_START: begin
        if (prog_sel) begin
          state_nx = WAIT_END;
        end else if (cnt == '0) begin
          fail_nx[cur] = 1'b1;
          state_nx     = NEXT;
        end
      end
      WAIT_END: begin
        if (!prog_sel) begin
          if (!res_sel) fail_nx[cur] = 1'b1;
          state_nx = NEXT;
        end else if (cnt == '0) begin
          tmo_nx[cur] = 1'b1;
          state_nx    = NEXT;
        end
      end
      NEXT: begin
        if (cur == T_FLASH) begin
          state_nx = DONE;
          cur_nx   = 2'd0;
        end else begin
          cur_nx   = 2'(cur + 2'd1);
          state_nx = SELECT;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort discards whatever the current test would have recorded this cycle.
    if (in_run && abort) begin
      state_nx   = DONE;
      cur_nx     = 2'd0;
      fail_nx    = fail_q;
      tmo_nx     = tmo_q;
      aborted_nx = 1'b1;
    end
    if (state_nx == PULSE) init_nx = onehot4(cur_nx);
  end

  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state) begin
      case (state_nx)
        PULSE:      cnt_nx = LD_INIT;
        WAIT_START: cnt_nx = LD_START;
        WAIT_END:   cnt_nx = LD_TMO;
        default:    cnt_nx = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nx = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= 2'd0;
      fail_q  <= 4'b0000;
      tmo_q   <= 4'b0000;
      init_q  <= 4'b0000;
      aborted <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur     <= cur_nx;
      fail_q  <= fail_nx;
      tmo_q   <= tmo_nx;
      init_q  <= init_nx;
      aborted <= aborted_nx;
    end
  end

  assign init      = init_q;
  assign busy      = in_run;
  assign done      = (state == DONE);
  assign all_pass  = done && !aborted && (fail_q == 4'b0000) && (tmo_q == 4'b0000);
  assign fail_mask = fail_q;
  assign tmo_mask  = tmo_q;
  assign cur_test  = cur;
  assign fsm_state = state;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with behavioural tester models and an
// init-pulse log compared against expected {index,length} entries.
module tb_test_sequencer;
  import test_seq_pkg::*;

  logic       clk, rst_n, start, abort;
  logic [3:0] test_enable, manual_req;
  logic       mem_progress, mem_result, sd_progress, sd_result, flash_progress, flash_result;
  logic [3:0] init, fail_mask, tmo_mask;
  logic       busy, done, all_pass;
  logic [1:0] cur_test;
  state_t     fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  int   hold_c[4];
  logic res_c[4];
  logic nostart_c[4];

  logic [7:0] pulse_q[$];
  logic [7:0] exp_q[$];
  int         run_len[4];

  test_sequencer #(.INIT_CYCLES(4), .START_CYCLES(64), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .test_enable(test_enable), .manual_req(manual_req),
    .mem_progress(mem_progress), .mem_result(mem_result),
    .sd_progress(sd_progress), .sd_result(sd_result),
    .flash_progress(flash_progress), .flash_result(flash_result),
    .init(init), .busy(busy), .done(done), .all_pass(all_pass),
    .fail_mask(fail_mask), .tmo_mask(tmo_mask), .cur_test(cur_test),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tester models: progress rises 5 cycles after init falls, held hold_c cycles
  for (genvar k = 0; k < 4; k++) begin : g_tester
    logic p;
    logic r;
    initial begin
      p = 1'b0;
      r = 1'b1;
      forever begin
        @(posedge init[k]);
        @(negedge init[k]);
        if (!nostart_c[k]) begin
          repeat (5) @(posedge clk);
          #1 r = res_c[k];
          p = 1'b1;
          repeat (hold_c[k]) @(posedge clk);
          #1 p = 1'b0;
          repeat (5) @(posedge clk);
          #1 r = 1'b1;
        end
      end
    end
  end

  assign mem_progress   = g_tester[0].p | g_tester[1].p;
  assign mem_result     = g_tester[0].r & g_tester[1].r;
  assign sd_progress    = g_tester[2].p;
  assign sd_result      = g_tester[2].r;
  assign flash_progress = g_tester[3].p;
  assign flash_result   = g_tester[3].r;

  // init pulse monitor: logs {bit index, high length} when a bit falls
  initial begin
    for (int i = 0; i < 4; i++) run_len[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (init[i]) begin
          run_len[i]++;
        end else if (run_len[i] != 0) begin
          pulse_q.push_back({2'(i), 6'(run_len[i])});
          run_len[i] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic models_default();
    for (int i = 0; i < 4; i++) begin
      hold_c[i]    = 100;
      res_c[i]     = 1'b1;
      nostart_c[i] = 1'b0;
    end
  endtask

  task automatic pulse_start(input logic [3:0] en);
    test_enable = en;
    pulse_q.delete();
    exp_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_state(input string tag, input state_t s, input logic [1:0] t, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fsm_state == s && cur_test == t) && n < budget);
    check({tag, "_reach"}, (fsm_state == s && cur_test == t), 1'b1);
  endtask

  task automatic expect_pulses(input logic [3:0] en);
    for (int i = 0; i < 4; i++)
      if (en[i]) exp_q.push_back({2'(i), 6'd4});
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_npulse"}, pulse_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++)
      check({tag, "_pulse"}, pulse_q[i], exp_q[i]);
  endtask

  task automatic check_result(input string tag, input logic [3:0] f, input logic [3:0] t,
                              input logic ap);
    check({tag, "_fail"}, fail_mask, f);
    check({tag, "_tmo"}, tmo_mask, t);
    check({tag, "_allpass"}, all_pass, ap);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    models_default();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    test_enable = 4'b1111; manual_req = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_init", init, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_masks", {fail_mask, tmo_mask}, 8'h00);
    check("rst_cur", cur_test, 2'd0);
    check("rst_state", fsm_state, IDLE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: all pass
    pulse_start(4'b1111);
    wait_done("t1", 3000);
    expect_pulses(4'b1111);
    check_pulses("t1");
    check_result("t1", 4'b0000, 4'b0000, 1'b1);
    repeat (20) @(negedge clk);

    // 2: SD fails, flash still runs
    res_c[2] = 1'b0;
    pulse_start(4'b1111);
    wait_done("t2", 3000);
    expect_pulses(4'b1111);
    check_pulses("t2");
    check_result("t2", 4'b0100, 4'b0000, 1'b0);
    models_default();
    repeat (20) @(negedge clk);

    // 3: flash never starts; no-start fault 64 cycles after its pulse ends
    nostart_c[3] = 1'b1;
    pulse_start(4'b1111);
    n = 0;
    while (!init[3] && n < 3000) begin @(negedge clk); n++; end
    check("t3_flash_init", init[3], 1'b1);
    while (init[3] && n < 3000) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!fail_mask[3] && n < 200);
    check("t3_nostart_lat", n, 64);
    wait_done("t3", 200);
    check_result("t3", 4'b1000, 4'b0000, 1'b0);
    models_default();
    repeat (20) @(negedge clk);

    // 4: mem-slow hangs past the timeout
    hold_c[1] = 1100;
    pulse_start(4'b1111);
    wait_done("t4", 5000);
    expect_pulses(4'b1111);
    check_pulses("t4");
    check_result("t4", 4'b0000, 4'b0010, 1'b0);
    models_default();
    repeat (50) @(negedge clk);

    // 5: only tests 0 and 2 enabled
    pulse_start(4'b0101);
    wait_done("t5", 3000);
    expect_pulses(4'b0101);
    check_pulses("t5");
    check_result("t5", 4'b0000, 4'b0000, 1'b1);
    repeat (20) @(negedge clk);

    // 6a: abort while SD is in progress
    pulse_start(4'b1111);
    wait_state("t6a", WAIT_END, 2'd2, 3000);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t6a_init", init, 4'b0000);
    check("t6a_done", done, 1'b1);
    check_result("t6a", 4'b0000, 4'b0000, 1'b0);
    repeat (150) @(negedge clk);

    // 6b: start and abort together -> nothing runs
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t6b_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("t6b_init", init, 4'b0000);
    check("t6b_state", fsm_state, DONE);

    // 6c: manual pass-through while not busy, one cycle of latency
    @(posedge clk); #1 manual_req = 4'b0100;
    @(negedge clk);
    check("t6c_man_pre", init, 4'b0000);
    @(negedge clk);
    check("t6c_man", init, 4'b0100);
    #1 manual_req = 4'b0000;
    repeat (150) @(negedge clk);

    // 6d: manual requests ignored while busy
    manual_req = 4'b0010;
    pulse_start(4'b0001);
    wait_state("t6d", WAIT_END, 2'd0, 500);
    check("t6d_man_busy", init, 4'b0000);
    wait_done("t6d", 500);
    @(negedge clk);
    check("t6d_man_done", init, 4'b0010);
    manual_req = 4'b0000;
    repeat (150) @(negedge clk);

    // 6e: reset mid-PULSE clears init without a clock edge
    pulse_start(4'b1111);
    n = 0;
    while (init == 4'b0000 && n < 100) begin @(negedge clk); n++; end
    check("t6e_pulse", init, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    check("t6e_init", init, 4'b0000);
    check("t6e_state", fsm_state, IDLE);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
